// File: rtl/date_entry.sv
// Keypad date setter: collects DDMMYYYY, validates it as a calendar date, pulses load.
// Optional macro DATE_ENTRY_BACKSPACE_EN adds an edge-detected backspace_key input.
module date_entry #(
    parameter int YEAR_MIN   = 0,
    parameter int YEAR_MAX   = 9999,
    parameter int RESET_YEAR = 2025
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        digit_key,
    input  logic [3:0]  digit,
    input  logic        enter_key,
    input  logic        cancel_key,
`ifdef DATE_ENTRY_BACKSPACE_EN
    input  logic        backspace_key,
`endif
    output logic        load,
    output logic [5:0]  load_day,
    output logic [3:0]  load_month,
    output logic [15:0] load_year,
    output logic [31:0] entry_bcd,
    output logic [3:0]  count,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] LOAD    = 3'd3;
    localparam logic [2:0] ERROR   = 3'd4;

    logic [2:0]      state;
    logic [7:0][3:0] buf_q;   // index 7 holds the first entered digit
    logic            digit_prev, enter_prev, cancel_prev;
    logic            cancel_ev, enter_ev, digit_ev;
    logic [2:0]      wr_idx;

`ifdef DATE_ENTRY_BACKSPACE_EN
    logic            bs_prev, bs_ev;
    logic [2:0]      bs_idx;
    assign bs_ev  = backspace_key & ~bs_prev & ~cancel_ev;
    assign bs_idx = 3'(4'd8 - count);
    assign enter_ev = enter_key & ~enter_prev & ~cancel_ev & ~bs_ev;
    assign digit_ev = digit_key & ~digit_prev & (digit <= 4'd9)
                    & ~cancel_ev & ~bs_ev & ~enter_ev;
`else
    assign enter_ev = enter_key & ~enter_prev & ~cancel_ev;
    assign digit_ev = digit_key & ~digit_prev & (digit <= 4'd9)
                    & ~cancel_ev & ~enter_ev;
`endif
    assign cancel_ev = cancel_key & ~cancel_prev;
    assign wr_idx    = 3'(4'd7 - count);

    assign entry_bcd = buf_q;
    assign load      = (state == LOAD);
    assign busy      = (state == COLLECT) || (state == CHECK) || (state == LOAD);

    // BCD to binary, straight from the registered buffer
    logic [6:0]        day_bin, mon_bin;
    logic [15:0]       year_bin;
    logic signed [31:0] year_s;
    logic [1:0]        cent_lo;
    logic              leap;
    logic [4:0]        max_days;
    logic [2:0]        chk_err;

    always_comb begin
        day_bin  = 7'(buf_q[7]) * 7'd10 + 7'(buf_q[6]);
        mon_bin  = 7'(buf_q[5]) * 7'd10 + 7'(buf_q[4]);
        year_bin = 16'(buf_q[3]) * 16'd1000 + 16'(buf_q[2]) * 16'd100
                 + 16'(buf_q[1]) * 16'd10 + 16'(buf_q[0]);
        year_s   = $signed({16'b0, year_bin});
        // century mod 4: 10*c1 + c0 == 2*c1 + c0 (mod 4)
        cent_lo  = {buf_q[3][0], 1'b0} + buf_q[2][1:0];
        leap     = ((year_bin[1:0] == 2'b00) && !(buf_q[1] == 4'd0 && buf_q[0] == 4'd0))
                || ((buf_q[1] == 4'd0) && (buf_q[0] == 4'd0) && (cent_lo == 2'b00));
        case (mon_bin)
            7'd2:                       max_days = leap ? 5'd29 : 5'd28;
            7'd4, 7'd6, 7'd9, 7'd11:    max_days = 5'd30;
            default:                    max_days = 5'd31;
        endcase
        chk_err = 3'd0;
        if (mon_bin == 7'd0 || mon_bin > 7'd12)
            chk_err = 3'd2;
        else if (year_s < YEAR_MIN || year_s > YEAR_MAX)
            chk_err = 3'd3;
        else if (day_bin == 7'd0 || day_bin > 7'(max_days))
            chk_err = 3'd4;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            buf_q       <= '1;
            count       <= 4'd0;
            err_code    <= 3'd0;
            load_day    <= 6'd1;
            load_month  <= 4'd1;
            load_year   <= RESET_YEAR[15:0];
            digit_prev  <= 1'b0;
            enter_prev  <= 1'b0;
            cancel_prev <= 1'b0;
`ifdef DATE_ENTRY_BACKSPACE_EN
            bs_prev     <= 1'b0;
`endif
        end else begin
            digit_prev  <= digit_key;
            enter_prev  <= enter_key;
            cancel_prev <= cancel_key;
`ifdef DATE_ENTRY_BACKSPACE_EN
            bs_prev     <= backspace_key;
`endif
            case (state)
                IDLE: begin
                    if (cancel_ev) begin
                        buf_q    <= '1;
                        count    <= 4'd0;
                        err_code <= 3'd0;
                    end else if (digit_ev) begin
                        buf_q    <= {digit, 28'hFFF_FFFF};
                        count    <= 4'd1;
                        err_code <= 3'd0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cancel_ev) begin
                        buf_q <= '1;
                        count <= 4'd0;
                        state <= IDLE;
                    end
`ifdef DATE_ENTRY_BACKSPACE_EN
                    else if (bs_ev) begin
                        buf_q[bs_idx] <= 4'hF;
                        count         <= count - 4'd1;
                        if (count == 4'd1) state <= IDLE;
                    end
`endif
                    else if (enter_ev) begin
                        if (count == 4'd8) begin
                            state <= CHECK;
                        end else begin
                            err_code <= 3'd1;
                            state    <= ERROR;
                        end
                    end else if (digit_ev && count < 4'd8) begin
                        buf_q[wr_idx] <= digit;
                        count         <= count + 4'd1;
                    end
                end
                CHECK: begin
                    if (chk_err == 3'd0) begin
                        load_day   <= day_bin[5:0];
                        load_month <= mon_bin[3:0];
                        load_year  <= year_bin;
                        state      <= LOAD;
                    end else begin
                        err_code <= chk_err;
                        state    <= ERROR;
                    end
                end
                LOAD: begin
                    buf_q <= '1;
                    count <= 4'd0;
                    state <= IDLE;
                end
                ERROR: begin
                    if (cancel_ev) begin
                        buf_q    <= '1;
                        count    <= 4'd0;
                        err_code <= 3'd0;
                        state    <= IDLE;
                    end else if (digit_ev) begin
                        buf_q    <= {digit, 28'hFFF_FFFF};
                        count    <= 4'd1;
                        err_code <= 3'd0;
                        state    <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
